// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, samples mid-bit, and holds one received
// byte in a valid/ready register with framing and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxd_s;
    logic                   rxd_prev_r;
    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;
    logic                   load_pend_r;

    // Metastability synchroniser for the asynchronous serial line, preset to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r     <= {SYNC_STAGES{1'b1}};
            rxd_prev_r <= 1'b1;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], rxd};
            rxd_prev_r <= rxd_s;
        end
    end

    assign rxd_s = sync_r[SYNC_STAGES-1];

    // Frame FSM: start detect, mid-bit sampling, stop check and completion flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            load_pend_r  <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            load_pend_r  <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Only a fresh 1->0 transition starts a frame; a held-low line is ignored.
                    if (rxd_prev_r && !rxd_s) begin
                        state_r   <= ST_START;
                        bit_cnt_r <= '0;
                        rx_busy   <= 1'b1;
                    end else begin
                        rx_busy   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_cnt_r == CNT_HALF) begin
                        bit_cnt_r <= '0;
                        bit_idx_r <= 3'd0;
                        if (!rxd_s) begin
                            state_r <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == CNT_LAST) begin
                        bit_cnt_r <= '0;
                        shift_r   <= {rxd_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_cnt_r == CNT_LAST) begin
                        bit_cnt_r    <= '0;
                        state_r      <= ST_IDLE;
                        rx_busy      <= 1'b0;
                        load_pend_r  <= rxd_s;
                        rx_frame_err <= !rxd_s;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: loads completed bytes, handles consume and overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (load_pend_r) begin
                // A byte consumed in the same cycle frees the slot for the new one.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: serial frames from a bit-level driver, expected
// bytes and error counts from a frame-level model, checked by a decoupled monitor.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int act_ferr = 0;
    int act_ovr  = 0;
    int valid_cycles = 0;
    bit busy_seen = 1'b0;

    bit   rand_ready = 1'b0;
    logic ready_val  = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_busy(rx_busy),
        .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer: either a fixed level or sparse random acceptance.
    always begin
        @(posedge clk);
        #1;
        rx_ready = rand_ready ? ($urandom_range(0, 7) == 0) : ready_val;
    end

    // Monitor: every accepted byte must be the next one the model expects.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (rx_frame_err) act_ferr++;
            if (rx_overrun)   act_ovr++;
            if (rx_busy)      busy_seen = 1'b1;
            if (rx_valid)     valid_cycles++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(CPB);
        end
        rxd = stop;
        wait_cyc(CPB);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_frame_err_count"}, act_ferr, exp_ferr);
        check({tag, "_overrun_count"}, act_ovr, exp_ovr);
    endtask

    initial begin
        logic [7:0] vals[256];

        // Reset state
        wait_cyc(4);
        @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_pulses", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cyc(10);

        // 1: single byte with consumer always ready
        ready_val = 1'b1;
        wait_cyc(2);
        valid_cycles = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cyc(3 * CPB);
        check("t1_valid_cycles", valid_cycles, 32'd1);
        check("t1_queue_drained", exp_q.size(), 32'd0);
        check_errs("t1");

        // 2: back-to-back frames with no consumer; second byte overruns
        ready_val = 1'b0;
        wait_cyc(2);
        exp_q.push_back(8'h3C);
        exp_ovr++;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_cyc(3 * CPB);
        @(negedge clk);
        check("t2_valid_held", {31'd0, rx_valid}, 32'd1);
        check("t2_data_kept", {24'd0, rx_data}, 32'h3C);
        check_errs("t2");
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        ready_val = 1'b0;
        wait_cyc(4);
        @(negedge clk);
        check("t2_valid_cleared", {31'd0, rx_valid}, 32'd0);
        check("t2_queue_drained", exp_q.size(), 32'd0);

        // 3: framing error, held-low line, then recovery
        ready_val = 1'b1;
        wait_cyc(2);
        exp_ferr++;
        send_frame(8'h55, 1'b0);
        wait_cyc(40);
        @(negedge clk);
        check("t3_no_valid", {31'd0, rx_valid}, 32'd0);
        check("t3_not_busy_low_line", {31'd0, rx_busy}, 32'd0);
        check_errs("t3a");
        @(posedge clk);
        #1;
        rxd = 1'b1;
        wait_cyc(2 * CPB);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_cyc(3 * CPB);
        check("t3_queue_drained", exp_q.size(), 32'd0);
        check("t3_data", {24'd0, rx_data}, 32'h12);
        check_errs("t3b");

        // 4: short glitch is rejected at the start-bit midpoint
        busy_seen = 1'b0;
        valid_cycles = 0;
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(2 * CPB);
        @(negedge clk);
        check("t4_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("t4_busy_fell", {31'd0, rx_busy}, 32'd0);
        check("t4_no_valid", valid_cycles, 32'd0);
        check_errs("t4");

        // 5: reset during data bit 3 of 8'hFF abandons the frame
        rxd = 1'b0;
        wait_cyc(CPB);
        rxd = 1'b1;
        wait_cyc(3 * CPB + CPB / 2);
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        @(negedge clk);
        check("t5_data_reset", {24'd0, rx_data}, 32'd0);
        check("t5_valid_reset", {31'd0, rx_valid}, 32'd0);
        check("t5_busy_reset", {31'd0, rx_busy}, 32'd0);
        wait_cyc(8 * CPB);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cyc(3 * CPB);
        check("t5_queue_drained", exp_q.size(), 32'd0);
        check("t5_data", {24'd0, rx_data}, 32'h81);
        check_errs("t5");

        // 6: all byte values in random order with a sparse random consumer
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j = $urandom_range(0, i);
            t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(vals[i]);
            send_frame(vals[i], 1'b1);
            wait_cyc($urandom_range(0, 12));
        end
        wait_cyc(4 * CPB);
        rand_ready = 1'b0;
        ready_val = 1'b1;
        wait_cyc(10);
        check("t6_all_bytes_seen", exp_q.size(), 32'd0);
        check_errs("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
